// File: rtl/hbmc_rfifo_pack_if.sv
// Handshake bundle between the HyperBus read datapath / bus-side read channel and the read FIFO.
// Parameters must match the hbmc_rfifo_pack instance the bundle is connected to.
interface hbmc_rfifo_pack_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 512
);
    localparam int N  = DATA_WIDTH / 16;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(N) + 1;

    logic                  fifo_clr;
    logic [15:0]           fifo_wr_din;
    logic                  fifo_wr_last;
    logic                  fifo_wr_ena;
    logic                  fifo_wr_full;
    logic                  fifo_wr_ovf;
    logic [DATA_WIDTH-1:0] fifo_rd_dout;
    logic                  fifo_rd_last;
    logic [LW-1:0]         fifo_rd_lanes;
    logic [AW:0]           fifo_rd_free;
    logic                  fifo_rd_ena;
    logic                  fifo_rd_empty;

    modport master (
        output fifo_clr, fifo_wr_din, fifo_wr_last, fifo_wr_ena, fifo_rd_ena,
        input  fifo_wr_full, fifo_wr_ovf, fifo_rd_dout, fifo_rd_last, fifo_rd_lanes,
               fifo_rd_free, fifo_rd_empty
    );

    modport slave (
        input  fifo_clr, fifo_wr_din, fifo_wr_last, fifo_wr_ena, fifo_rd_ena,
        output fifo_wr_full, fifo_wr_ovf, fifo_rd_dout, fifo_rd_last, fifo_rd_lanes,
               fifo_rd_free, fifo_rd_empty
    );
endinterface

// File: rtl/hbmc_rfifo_pack.sv
// Single-clock read FIFO: packs 16-bit half-words into DATA_WIDTH words (first half-word in MSBs),
// closes partial words on burst-final half-words, and presents the head word first-word-fall-through.
module hbmc_rfifo_pack #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 512
) (
    input logic              fifo_clk,
    input logic              fifo_arst,
    hbmc_rfifo_pack_if.slave bus
);
    localparam int N  = DATA_WIDTH / 16;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(N) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 1 + LW;

    if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64 || DATA_WIDTH == 128)) begin : g_bad_dw
        $error("hbmc_rfifo_pack: DATA_WIDTH must be 16, 32, 64 or 128");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hbmc_rfifo_pack: FIFO_DEPTH must be a power of two >= 4");
    end

    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] pack_q;
    logic [DATA_WIDTH-1:0] word_c;
    logic [LW-1:0]         lanes_c;
    logic [EW-1:0]         wentry;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q, rptr_n;
    logic [AW:0]           count_q, count_n, free_q;
    logic                  full_q, empty_q, ovf_q;
    logic [EW-1:0]         head_q, head_n;
    logic                  wr_ok, commit, pop;

    assign wr_ok  = bus.fifo_wr_ena & ~full_q;
    assign commit = wr_ok & (bus.fifo_wr_last | (cnt_q == CW'(N - 1)));
    assign pop    = bus.fifo_rd_ena & ~empty_q;

    // Unfilled lanes are already zero in pack_q because it is cleared on every commit.
    always_comb begin
        word_c = pack_q;
        word_c[DATA_WIDTH - 1 - 16 * int'(cnt_q) -: 16] = bus.fifo_wr_din;
        lanes_c = LW'(cnt_q) + LW'(1);
        wentry  = {word_c, bus.fifo_wr_last, lanes_c};
    end

    always_comb begin
        count_n = count_q + (AW + 1)'(commit) - (AW + 1)'(pop);
        rptr_n  = rptr_q + AW'(pop);
        head_n  = '0;
        if (count_n != '0) begin
            // When the incoming word is the only one left it bypasses the RAM into the head register.
            if (count_q == (AW + 1)'(pop)) head_n = wentry;
            else                           head_n = mem[rptr_n];
        end
    end

    always_ff @(posedge fifo_clk or posedge fifo_arst) begin
        if (fifo_arst) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else if (bus.fifo_clr) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else if (wr_ok) begin
            if (commit) begin
                cnt_q  <= '0;
                pack_q <= '0;
            end else begin
                cnt_q  <= cnt_q + CW'(1);
                pack_q <= word_c;
            end
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (commit && !bus.fifo_clr) mem[wptr_q] <= wentry;
    end

    always_ff @(posedge fifo_clk or posedge fifo_arst) begin
        if (fifo_arst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            free_q  <= (AW + 1)'(FIFO_DEPTH);
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            head_q  <= '0;
        end else if (bus.fifo_clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            free_q  <= (AW + 1)'(FIFO_DEPTH);
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            head_q  <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(commit);
            rptr_q  <= rptr_n;
            count_q <= count_n;
            free_q  <= (AW + 1)'(FIFO_DEPTH) - count_n;
            full_q  <= (count_n == (AW + 1)'(FIFO_DEPTH));
            empty_q <= (count_n == '0);
            head_q  <= head_n;
            if (bus.fifo_wr_ena && full_q) ovf_q <= 1'b1;
        end
    end

    assign bus.fifo_wr_full  = full_q;
    assign bus.fifo_wr_ovf   = ovf_q;
    assign bus.fifo_rd_empty = empty_q;
    assign bus.fifo_rd_free  = free_q;
    assign bus.fifo_rd_dout  = head_q[EW-1 -: DATA_WIDTH];
    assign bus.fifo_rd_last  = head_q[LW];
    assign bus.fifo_rd_lanes = head_q[LW-1:0];
endmodule
